// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_pkg
// Description : Shared constants for the IF/ID pipeline register slice.
//               Instruction/memory widths and the NOP opcode that the
//               squash logic inserts on wrong-path slots.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_stage_pkg;

    // Instruction word width and instruction-memory address width
    localparam int WIDTH_INSTR_MEM  = 16;
    localparam int LENGTH_INSTR_MEM = 10;

    // Opcode field width and the opcode used for bubbles / squashed slots
    localparam int OPC_WIDTH = 6;
    localparam int OPC_NOP   = 'h3F;

    // Maximum value held by the 3-bit remaining-squash counter
    localparam int SQ_MAX = 7;

endpackage : if_id_stage_pkg
`default_nettype wire

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_if
// Description : Fetch-side / decode-side signal bundle of the IF/ID stage.
//   master : fetch/control side - drives fetched instruction, PC+1, branch
//            flush and decode stall; observes the registered outputs.
//   slave  : the IF/ID stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_stage_if #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 6,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8
);
    logic [INSTR_W-1:0]       iFetchedInst;
    logic [ADDR_W-1:0]        iNew_pc;
    logic                     iBr_taken;
    logic                     iStall;
    logic [INSTR_W-1:0]       oInstr;
    logic [OPC_W-1:0]         oOpcode;
    logic [INSTR_W-OPC_W-1:0] oOperand;
    logic [ADDR_W-1:0]        oPc_plus1;
    logic                     oValid;
    logic                     oHoldPc;
    logic [CNT_W-1:0]         oSquashCnt;

    modport master (
        output iFetchedInst, iNew_pc, iBr_taken, iStall,
        input  oInstr, oOpcode, oOperand, oPc_plus1, oValid, oHoldPc, oSquashCnt
    );

    modport slave (
        input  iFetchedInst, iNew_pc, iBr_taken, iStall,
        output oInstr, oOpcode, oOperand, oPc_plus1, oValid, oHoldPc, oSquashCnt
    );
endinterface : if_id_stage_if
`default_nettype wire

// File: rtl/if_id_squash_ctl.sv
`default_nettype none
// ============================================================================
// Module      : if_id_squash_ctl
// Description : Flush/stall control for the IF/ID register. Tracks how many
//               wrong-path slots remain to be killed after a taken branch and
//               keeps a saturating count of all squashed slots.
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   br_taken   in   flush request
//   stall      in   decode cannot accept
//   load_en    out  datapath registers load this edge
//   insert_nop out  the loaded slot is a NOP (valid=0)
//   squash_cnt out  squashed slots since reset, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_squash_ctl
    import if_id_stage_pkg::*;
#(
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             br_taken,
    input  wire logic             stall,
    output logic                  load_en,
    output logic                  insert_nop,
    output logic [CNT_W-1:0]      squash_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    // Slots still to kill after the branch slot itself
    localparam logic [2:0] C_SQ_INIT = 3'(SQUASH_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [2:0]       sq_q, sq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            sq_q    <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: flush beats stall; a stall freezes sq as well
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        if (br_taken) begin
            sq_d    = C_SQ_INIT;
            state_d = (C_SQ_INIT != 3'd0) ? ST_SQUASH : ST_RUN;
        end else if (!stall && (state_q == ST_SQUASH)) begin
            sq_d = sq_q - 3'd1;
            if (sq_q <= 3'd1) begin
                state_d = ST_RUN;
            end
        end
    end

    // Output logic
    always_comb begin
        load_en    = br_taken | ~stall;
        insert_nop = br_taken | (~stall & (state_q == ST_SQUASH));
        cnt_inc    = load_en & insert_nop;
    end

    // Saturating squash counter: never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign squash_cnt = cnt_q;

endmodule : if_id_squash_ctl
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : IF/ID pipeline register. Captures the fetched instruction and
//               its PC+1 with one clock of latency, tags it valid, holds on a
//               decode stall and replaces wrong-path slots with NOPs after a
//               taken branch.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   bus    slave modport: iFetchedInst, iNew_pc, iBr_taken, iStall in;
//          oInstr, oOpcode, oOperand, oPc_plus1, oValid, oHoldPc,
//          oSquashCnt out
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int INSTR_W       = WIDTH_INSTR_MEM,
    parameter int OPC_W         = OPC_WIDTH,
    parameter int ADDR_W        = LENGTH_INSTR_MEM,
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    if_id_stage_if.slave   bus
);

    localparam logic [OPC_W-1:0]   C_NOP_OPC   = OPC_W'(OPC_NOP);
    localparam logic [INSTR_W-1:0] C_NOP_INSTR = {C_NOP_OPC, {(INSTR_W-OPC_W){1'b0}}};

    logic               load_en;
    logic               insert_nop;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    if_id_squash_ctl #(
        .SQUASH_CYCLES (SQUASH_CYCLES),
        .CNT_W         (CNT_W)
    ) u_squash_ctl (
        .clk        (clk),
        .reset      (reset),
        .br_taken   (bus.iBr_taken),
        .stall      (bus.iStall),
        .load_en    (load_en),
        .insert_nop (insert_nop),
        .squash_cnt (bus.oSquashCnt)
    );

    // PC+1 is captured even on squashed slots; decode must gate on valid
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (load_en) begin
            instr_d = insert_nop ? C_NOP_INSTR : bus.iFetchedInst;
            pc_d    = bus.iNew_pc;
            valid_d = ~insert_nop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= C_NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.oInstr    = instr_q;
    assign bus.oOpcode   = instr_q[INSTR_W-1 -: OPC_W];
    assign bus.oOperand  = instr_q[INSTR_W-OPC_W-1:0];
    assign bus.oPc_plus1 = pc_q;
    assign bus.oValid    = valid_q;
    // A flush overrides the stall, so fetch must move to the branch target
    assign bus.oHoldPc   = bus.iStall & ~bus.iBr_taken;

endmodule : if_id_stage
`default_nettype wire
